regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Writeback stage directly upstream of the 32x32 register file write port (we3/A3/WD3).
//  Accepts results from two producers (ALU, load unit) over valid/ready and buffers them in a
//  DEPTH-entry FIFO. Drains one write per cycle into the register file.
//  Exports a pending-write scoreboard so decode can stall on RAW hazards.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of 2, >=2
//  ADDR_W   5   register index width; 32 registers
//  DATA_W   32  register data width
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  ld_valid   in   1       load result valid
//  ld_ready   out  1       load result accepted when ld_valid&&ld_ready at posedge
//  ld_addr    in   ADDR_W  load destination register
//  ld_data    in   DATA_W  load result
//  alu_valid  in   1       ALU result valid
//  alu_ready  out  1       ALU result accepted when alu_valid&&alu_ready at posedge
//  alu_addr   in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  wr_stall   in   1       1 = register file write port unavailable this cycle; hold FIFO head
//  we3        out  1       register file write enable (registered)
//  A3         out  ADDR_W  register file write address (registered)
//  WD3        out  DATA_W  register file write data (registered)
//  pending    out  32      bit r=1: a write to register r is queued or on we3; bit 0 always 0
//  count      out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO emptied (pointers, count=0). we3=0, A3=0, WD3=0, pending=0.
//    Data in FIFO storage needs no reset. Reset mid-drain discards all queued writes.
//  Arbitration: fixed priority, load over ALU. At most one push per cycle.
//    ld_ready  = (count<DEPTH)
//    alu_ready = (count<DEPTH) && !ld_valid
//    Both ready signals are combinational from count and ld_valid only (no valid->ready loop
//    on the same port).
//  $0 rule: an accepted transfer with addr==0 completes its handshake but is not enqueued.
//  Pop: at posedge, if count>0 && !wr_stall, the head is popped and registered into
//    A3/WD3 with we3=1. Otherwise we3<=0; A3/WD3 hold their previous values.
//  Latency: a push at edge N can pop at the earliest at edge N+1, so we3=1 during cycle
//    N+1..N+2 and the register file commits at edge N+2. There is no same-cycle pass-through.
//  Simultaneous push+pop: allowed in the same cycle; count is unchanged. When count==DEPTH,
//    ready=0 even if a pop occurs in that cycle. Order is strictly FIFO, so two writes to the
//    same register commit in acceptance order.
//  Pointers: rd/wr pointers of log2(DEPTH) bits wrap modulo DEPTH; count disambiguates
//    full from empty.
//  pending: combinational OR of one-hot(addr) over valid FIFO entries, ORed with one-hot(A3)
//    when we3=1. bit0 is forced to 0. A bit clears only after the last queued write to that
//    register has left the we3 stage.
//  wr_stall held high: FIFO fills to DEPTH, then both ready signals drop. No entry is lost or
//    duplicated.
// TESTING
//  1 Reset: assert rst_n=0 mid-operation with count=3 -> immediately we3=0, count=0, pending=0;
//    after release, ld_ready=alu_ready=1.
//  2 Single ALU write: alu_valid with addr=5, data=0xDEADBEEF at edge 0 -> we3=1, A3=5,
//    WD3=0xDEADBEEF in cycle 1; pending[5]=1 in cycles 0..1; pending[5]=0 in cycle 2.
//  3 Contention: ld(addr 3, 0x11) and alu(addr 4, 0x22) valid together -> load accepted,
//    alu_ready=0. Next cycle ALU is accepted. Writes appear on A3 in order 3, then 4.
//  4 $0 discard: alu addr=0, data=0xFFFFFFFF accepted -> count stays 0, we3 never asserts,
//    pending stays 0.
//  5 Full/stall: wr_stall=1 with 6 back-to-back ALU pushes -> first 4 accepted, alu_ready=0
//    at count=4. Release stall -> 4 writes on consecutive cycles in order, with wrap checked.
//  6 Same-register ordering: pushes to r7 of 0x1 then 0x2 -> WD3 shows 0x1 then 0x2;
//    pending[7] clears only after 0x2 has left we3.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback stage ahead of the 32x32 register file write port.
// Arbitrates load and ALU results (load first) into a small FIFO and drains one
// write per cycle onto we3/A3/WD3. Exports a pending-write mask for RAW stalls.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     wr_stall,
  output logic                     we3,
  output logic [ADDR_W-1:0]        A3,
  output logic [DATA_W-1:0]        WD3,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              we3_r;
  logic [ADDR_W-1:0] a3_r;
  logic [DATA_W-1:0] wd3_r;

  logic              not_full_s;
  logic              push_s;
  logic              enq_s;
  logic              pop_s;
  logic [ADDR_W-1:0] push_addr_s;
  logic [DATA_W-1:0] push_data_s;
  logic [PTR_W-1:0]  offset_s;
  logic [31:0]       pending_s;

  // Readiness depends only on occupancy and ld_valid, never on the port's own valid.
  assign not_full_s = (count_r < FULL_CNT);
  assign ld_ready   = not_full_s;
  assign alu_ready  = not_full_s && !ld_valid;

  // Fixed-priority arbitration: the load unit wins over the ALU.
  always_comb begin
    push_s      = 1'b0;
    push_addr_s = '0;
    push_data_s = '0;
    if (ld_valid && ld_ready) begin
      push_s      = 1'b1;
      push_addr_s = ld_addr;
      push_data_s = ld_data;
    end else if (alu_valid && alu_ready) begin
      push_s      = 1'b1;
      push_addr_s = alu_addr;
      push_data_s = alu_data;
    end else begin
      push_s      = 1'b0;
    end
  end

  // Writes to $0 finish their handshake but are dropped instead of queued.
  assign enq_s = push_s && (push_addr_s != '0);
  assign pop_s = (count_r != '0) && !wr_stall;

  // FIFO pointers and occupancy; count tells full apart from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_r[wr_ptr_r] <= push_addr_s;
      data_mem_r[wr_ptr_r] <= push_data_s;
    end else begin
      addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
    end
  end

  // Register-file write port: pop the head unless stalled; address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_r <= 1'b0;
      a3_r  <= '0;
      wd3_r <= '0;
    end else if (pop_s) begin
      we3_r <= 1'b1;
      a3_r  <= addr_mem_r[rd_ptr_r];
      wd3_r <= data_mem_r[rd_ptr_r];
    end else begin
      we3_r <= 1'b0;
      a3_r  <= a3_r;
      wd3_r <= wd3_r;
    end
  end

  // Pending mask: every live FIFO entry plus the write currently on we3; $0 never pending.
  always_comb begin
    pending_s = 32'h0000_0000;
    offset_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset_s = PTR_W'(i) - rd_ptr_r;
      if ({1'b0, offset_s} < count_r) begin
        pending_s[addr_mem_r[i]] = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
    if (we3_r) begin
      pending_s[a3_r] = 1'b1;
    end else begin
      pending_s = pending_s;
    end
    pending_s[0] = 1'b0;
  end

  assign we3     = we3_r;
  assign A3      = a3_r;
  assign WD3     = wd3_r;
  assign pending = pending_s;
  assign count   = count_r;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: stimulus queues the expected writes,
// a monitor compares every we3 beat against the queue head.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        wr_stall;
  logic        we3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] pending;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_kind = 0;   // 0 none, 1 load, 2 alu accepted on last step
  int          n_acc    = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;

  regfile_writeback #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .wr_stall  (wr_stall),
    .we3       (we3),
    .A3        (A3),
    .WD3       (WD3),
    .pending   (pending),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; queue the expected write if accepted.
  task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic st);
    @(negedge clk);
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldd;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    wr_stall  = st;
    #1;
    if (lv && ld_ready) begin
      acc_kind = 1;
      if (la != 5'd0) exp_q.push_back({la, ldd});
    end else if (av && alu_ready) begin
      acc_kind = 2;
      if (aa != 5'd0) exp_q.push_back({aa, ad});
    end else begin
      acc_kind = 0;
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st);
  endtask

  // Monitor: each register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we3) begin
      if (exp_q.size() == 0) begin
        chk("we3_unexpected", {31'd0, we3}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_A3", {27'd0, A3}, {27'd0, mon_e[36:32]});
        chk("sb_WD3", WD3, mon_e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0; wr_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_pending", pending, 32'd0);

    // 1: asynchronous reset mid-drain with three entries queued and one on we3
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_00A1, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_00A2, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_00A3, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_00A4, 1'b1);
    idle(1'b0);
    idle(1'b1);
    chk("t1_count3", {29'd0, count}, 32'd3);
    chk("t1_we3", {31'd0, we3}, 32'd1);
    chk("t1_pending", pending, 32'h0000_001E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_we3", {31'd0, we3}, 32'd0);
    chk("t1_rst_count", {29'd0, count}, 32'd0);
    chk("t1_rst_pending", pending, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wr_stall = 1'b0;
    #1;
    chk("t1_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);

    // 2: single ALU write and pending timing
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    chk("t2_pend_before", {31'd0, pending[5]}, 32'd0);
    idle(1'b0);
    chk("t2_c0_pend", {31'd0, pending[5]}, 32'd1);
    chk("t2_c0_we3", {31'd0, we3}, 32'd0);
    chk("t2_c0_count", {29'd0, count}, 32'd1);
    idle(1'b0);
    chk("t2_c1_we3", {31'd0, we3}, 32'd1);
    chk("t2_c1_A3", {27'd0, A3}, 32'd5);
    chk("t2_c1_WD3", WD3, 32'hDEAD_BEEF);
    chk("t2_c1_pend", {31'd0, pending[5]}, 32'd1);
    idle(1'b0);
    chk("t2_c2_pend", {31'd0, pending[5]}, 32'd0);
    chk("t2_c2_we3", {31'd0, we3}, 32'd0);

    // 3: load wins contention, ALU follows next cycle
    step(1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd4, 32'h0000_0022, 1'b0);
    chk("t3_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("t3_ld_acc", acc_kind, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0022, 1'b0);
    chk("t3_alu_acc", acc_kind, 32'd2);
    idle(1'b0);
    chk("t3_first_A3", {27'd0, A3}, 32'd3);
    idle(1'b0);
    chk("t3_second_A3", {27'd0, A3}, 32'd4);
    idle(1'b0);

    // 4: write to $0 handshakes but is dropped
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    chk("t4_acc", acc_kind, 32'd2);
    idle(1'b0);
    chk("t4_count", {29'd0, count}, 32'd0);
    chk("t4_pending", pending, 32'd0);
    idle(1'b0);
    chk("t4_we3", {31'd0, we3}, 32'd0);

    // 5: stall fills the FIFO (pointers start at 3, so they wrap)
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(32'h100 + i), 1'b1);
      if (acc_kind == 2) n_acc++;
      if (i >= 4) begin
        chk("t5_alu_ready_full", {31'd0, alu_ready}, 32'd0);
        chk("t5_ld_ready_full", {31'd0, ld_ready}, 32'd0);
      end
    end
    chk("t5_accepted", n_acc, 32'd4);
    chk("t5_count_full", {29'd0, count}, 32'd4);
    idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      chk("t5_drain_we3", {31'd0, we3}, 32'd1);
      chk("t5_drain_A3", {27'd0, A3}, 32'(10 + k));
    end
    idle(1'b0);
    chk("t5_done_we3", {31'd0, we3}, 32'd0);
    chk("t5_done_count", {29'd0, count}, 32'd0);

    // 6: same-register ordering and pending hold
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0001, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0002, 1'b0);
    chk("t6_pend_q", {31'd0, pending[7]}, 32'd1);
    idle(1'b0);
    chk("t6_first_WD3", WD3, 32'h0000_0001);
    chk("t6_pend_1", {31'd0, pending[7]}, 32'd1);
    idle(1'b0);
    chk("t6_second_WD3", WD3, 32'h0000_0002);
    chk("t6_pend_2", {31'd0, pending[7]}, 32'd1);
    idle(1'b0);
    chk("t6_pend_clear", {31'd0, pending[7]}, 32'd0);

    idle(1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
